// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_pkg
//  Description : Shared sizing constants and types for the RV32I register
//                file and its pending-load scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;
    localparam int CNTW   = 2;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xword_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/regs_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regs_scoreboard
//  Description : Per-register pending-load counters. Decode registers each
//                issued load, writeback retires it, and a load-use stall is
//                raised while a used source still awaits load data.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                rd_addr_i/rd_wen_i/mem_re_i - writeback retire port
//                rsN_addr_i/rsN_used_i       - decode source operands
//                issue_*_i, flush_i          - decode issue port
//                load_use_stall_o            - combinational stall
//                sb_err_o                    - sticky over/underflow flag
//  Revision    : 1.0 - initial release
// ============================================================================
module regs_scoreboard
    import rv32_pkg::reg_addr_t, rv32_pkg::REG_ZERO;
#(
    parameter int NREG = rv32_pkg::NREG,
    parameter int CNTW = rv32_pkg::CNTW
) (
    input  logic      clk,
    input  logic      rst,
    input  reg_addr_t rd_addr_i,
    input  logic      rd_wen_i,
    input  logic      mem_re_i,
    input  reg_addr_t rs1_addr_i,
    input  reg_addr_t rs2_addr_i,
    input  logic      rs1_used_i,
    input  logic      rs2_used_i,
    input  logic      issue_valid_i,
    input  logic      issue_load_i,
    input  reg_addr_t issue_rd_i,
    input  logic      flush_i,
    output logic      load_use_stall_o,
    output logic      sb_err_o
);

    localparam logic [CNTW-1:0] c_cnt_zero = '0;
    localparam logic [CNTW-1:0] c_cnt_one  = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] c_cnt_max  = '1;

    logic [CNTW-1:0] r_cnt     [NREG];
    logic [CNTW-1:0] w_cnt_nxt [NREG];
    logic [NREG-1:0] w_err_vec;
    logic            r_err;

    logic            w_issue_fire;
    logic            w_retire;
    logic            w_rs1_pending;
    logic            w_rs2_pending;

    // The stall gates the issue, so a held issue_valid_i never double-counts.
    assign w_issue_fire = issue_valid_i & ~flush_i & ~load_use_stall_o &
                          issue_load_i & (issue_rd_i != REG_ZERO);
    assign w_retire     = rd_wen_i & mem_re_i & (rd_addr_i != REG_ZERO);

    // A source is still pending unless this cycle's retire drains its last
    // count; in that case the read is served by the writeback bypass.
    assign w_rs1_pending = (r_cnt[rs1_addr_i] != c_cnt_zero) &&
                           !(w_retire && (rd_addr_i == rs1_addr_i) &&
                             (r_cnt[rs1_addr_i] == c_cnt_one));
    assign w_rs2_pending = (r_cnt[rs2_addr_i] != c_cnt_zero) &&
                           !(w_retire && (rd_addr_i == rs2_addr_i) &&
                             (r_cnt[rs2_addr_i] == c_cnt_one));

    assign load_use_stall_o = (rs1_used_i && (rs1_addr_i != REG_ZERO) && w_rs1_pending) ||
                              (rs2_used_i && (rs2_addr_i != REG_ZERO) && w_rs2_pending);

    // Both fire and retire are gated on a nonzero address, so entry 0
    // never leaves its reset value of zero.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            w_cnt_nxt[r] = r_cnt[r];
            w_err_vec[r] = 1'b0;
            if (w_issue_fire && (issue_rd_i == reg_addr_t'(r)) &&
                !(w_retire && (rd_addr_i == reg_addr_t'(r)))) begin
                if (r_cnt[r] == c_cnt_max) begin
                    w_err_vec[r] = 1'b1;
                end else begin
                    w_cnt_nxt[r] = r_cnt[r] + c_cnt_one;
                end
            end else if (w_retire && (rd_addr_i == reg_addr_t'(r)) &&
                         !(w_issue_fire && (issue_rd_i == reg_addr_t'(r)))) begin
                if (r_cnt[r] == c_cnt_zero) begin
                    w_err_vec[r] = 1'b1;
                end else begin
                    w_cnt_nxt[r] = r_cnt[r] - c_cnt_one;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= c_cnt_zero;
            end
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_err <= r_err | (|w_err_vec);
        end
    end

    assign sb_err_o = r_err;

endmodule
`default_nettype wire

// File: rtl/regs.sv
`default_nettype none
// ============================================================================
//  Module      : regs
//  Description : RV32I architectural register file x0-x31 with two
//                combinational read ports, same-cycle writeback bypass and
//                a pending-load scoreboard producing the load-use stall.
//  Ports       : clk, rst                    - clock, sync active-high reset
//                rd_addr_i/rd_data_i/rd_wen_i - writeback write port
//                mem_re_i                     - writeback is a load retire
//                rsN_addr_i/rsN_used_i        - decode read ports
//                rsN_data_o                   - read data
//                issue_valid_i/issue_load_i/issue_rd_i/flush_i - issue port
//                load_use_stall_o, sb_err_o   - hazard and error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module regs
    import rv32_pkg::reg_addr_t, rv32_pkg::REG_ZERO;
#(
    parameter int NREG = rv32_pkg::NREG,
    parameter int XLEN = rv32_pkg::XLEN,
    parameter int CNTW = rv32_pkg::CNTW
) (
    input  logic            clk,
    input  logic            rst,
    input  reg_addr_t       rd_addr_i,
    input  logic [XLEN-1:0] rd_data_i,
    input  logic            rd_wen_i,
    input  logic            mem_re_i,
    input  reg_addr_t       rs1_addr_i,
    input  reg_addr_t       rs2_addr_i,
    input  logic            rs1_used_i,
    input  logic            rs2_used_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    input  logic            issue_valid_i,
    input  logic            issue_load_i,
    input  reg_addr_t       issue_rd_i,
    input  logic            flush_i,
    output logic            load_use_stall_o,
    output logic            sb_err_o
);

    logic [XLEN-1:0] r_regs [NREG];
    logic            w_wr_en;

    assign w_wr_en = rd_wen_i && (rd_addr_i != REG_ZERO);

    // Entry 0 is only ever reset; reads of x0 are forced to zero below.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[rd_addr_i] <= rd_data_i;
        end
    end

    always_comb begin
        rs1_data_o = r_regs[rs1_addr_i];
        if (rs1_addr_i == REG_ZERO) begin
            rs1_data_o = '0;
        end else if (w_wr_en && (rd_addr_i == rs1_addr_i)) begin
            rs1_data_o = rd_data_i;
        end
    end

    always_comb begin
        rs2_data_o = r_regs[rs2_addr_i];
        if (rs2_addr_i == REG_ZERO) begin
            rs2_data_o = '0;
        end else if (w_wr_en && (rd_addr_i == rs2_addr_i)) begin
            rs2_data_o = rd_data_i;
        end
    end

    regs_scoreboard #(
        .NREG (NREG),
        .CNTW (CNTW)
    ) u_scoreboard (
        .clk              (clk),
        .rst              (rst),
        .rd_addr_i        (rd_addr_i),
        .rd_wen_i         (rd_wen_i),
        .mem_re_i         (mem_re_i),
        .rs1_addr_i       (rs1_addr_i),
        .rs2_addr_i       (rs2_addr_i),
        .rs1_used_i       (rs1_used_i),
        .rs2_used_i       (rs2_used_i),
        .issue_valid_i    (issue_valid_i),
        .issue_load_i     (issue_load_i),
        .issue_rd_i       (issue_rd_i),
        .flush_i          (flush_i),
        .load_use_stall_o (load_use_stall_o),
        .sb_err_o         (sb_err_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regs
//  Description : Self-checking bench for regs. A reference model of the
//                register file and load counters predicts each cycle's
//                outputs; a monitor compares them against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic        rd_wen_i;
    logic        mem_re_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        rs1_used_i;
    logic        rs2_used_i;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic        issue_valid_i;
    logic        issue_load_i;
    logic [4:0]  issue_rd_i;
    logic        flush_i;
    logic        load_use_stall_o;
    logic        sb_err_o;

    always #5 clk = ~clk;

    regs dut (
        .clk              (clk),
        .rst              (rst),
        .rd_addr_i        (rd_addr_i),
        .rd_data_i        (rd_data_i),
        .rd_wen_i         (rd_wen_i),
        .mem_re_i         (mem_re_i),
        .rs1_addr_i       (rs1_addr_i),
        .rs2_addr_i       (rs2_addr_i),
        .rs1_used_i       (rs1_used_i),
        .rs2_used_i       (rs2_used_i),
        .rs1_data_o       (rs1_data_o),
        .rs2_data_o       (rs2_data_o),
        .issue_valid_i    (issue_valid_i),
        .issue_load_i     (issue_load_i),
        .issue_rd_i       (issue_rd_i),
        .flush_i          (flush_i),
        .load_use_stall_o (load_use_stall_o),
        .sb_err_o         (sb_err_o)
    );

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        stall;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;

    // Reference model: architectural values, loads outstanding per register,
    // and the sticky error bit.
    logic [31:0] m_regs [32];
    int          m_pend [32];
    bit          m_err;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_pend[i] = 0;
        end
        m_err = 1'b0;
    endtask

    function automatic logic [31:0] model_read(logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (rd_wen_i && rd_addr_i == a) return rd_data_i;
        return m_regs[a];
    endfunction

    // A source waits while loads remain outstanding after this cycle's retire.
    function automatic bit src_waits(bit used, logic [4:0] a);
        int remaining;
        if (!used || a == 5'd0) return 1'b0;
        remaining = m_pend[a];
        if (rd_wen_i && mem_re_i && rd_addr_i == a) remaining = remaining - 1;
        return remaining > 0;
    endfunction

    task automatic model_update(bit stall);
        bit issued;
        bit retired;
        if (rst) begin
            model_reset();
            return;
        end
        if (rd_wen_i && rd_addr_i != 5'd0) m_regs[rd_addr_i] = rd_data_i;
        issued  = issue_valid_i && !flush_i && !stall && issue_load_i && issue_rd_i != 5'd0;
        retired = rd_wen_i && mem_re_i && rd_addr_i != 5'd0;
        if (issued && retired && issue_rd_i == rd_addr_i) return;
        if (issued) begin
            if (m_pend[issue_rd_i] == 3) m_err = 1'b1;
            else m_pend[issue_rd_i] = m_pend[issue_rd_i] + 1;
        end
        if (retired) begin
            if (m_pend[rd_addr_i] == 0) m_err = 1'b1;
            else m_pend[rd_addr_i] = m_pend[rd_addr_i] - 1;
        end
    endtask

    task automatic idle();
        rst           = 1'b0;
        rd_addr_i     = 5'd0;
        rd_data_i     = 32'h0;
        rd_wen_i      = 1'b0;
        mem_re_i      = 1'b0;
        rs1_addr_i    = 5'd0;
        rs2_addr_i    = 5'd0;
        rs1_used_i    = 1'b0;
        rs2_used_i    = 1'b0;
        issue_valid_i = 1'b0;
        issue_load_i  = 1'b0;
        issue_rd_i    = 5'd0;
        flush_i       = 1'b0;
    endtask

    // Called at posedge+1 with inputs already applied: predict, clock, update.
    task automatic step();
        exp_t e;
        bit   stall;
        stall   = src_waits(rs1_used_i, rs1_addr_i) || src_waits(rs2_used_i, rs2_addr_i);
        e.rs1   = model_read(rs1_addr_i);
        e.rs2   = model_read(rs2_addr_i);
        e.stall = stall;
        e.err   = m_err;
        q.push_back(e);
        @(posedge clk);
        model_update(stall);
        #1;
    endtask

    task automatic load_issue(logic [4:0] r);
        idle();
        issue_valid_i = 1'b1;
        issue_load_i  = 1'b1;
        issue_rd_i    = r;
    endtask

    task automatic wb_load(logic [4:0] r, logic [31:0] d);
        rd_wen_i  = 1'b1;
        mem_re_i  = 1'b1;
        rd_addr_i = r;
        rd_data_i = d;
    endtask

    // Monitor: outputs are settled mid-cycle, compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rs1_data", rs1_data_o, e.rs1);
                chk("rs2_data", rs2_data_o, e.rs2);
                chk("load_use_stall", {31'h0, load_use_stall_o}, {31'h0, e.stall});
                chk("sb_err", {31'h0, sb_err_o}, {31'h0, e.err});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();

        // Reset state and x0 behaviour
        idle(); rs1_addr_i = 5'd5; rs1_used_i = 1'b1; step();
        idle(); rd_wen_i = 1'b1; rd_addr_i = 5'd0; rd_data_i = 32'hDEADBEEF; step();
        idle(); rs1_used_i = 1'b1; rs2_used_i = 1'b1; step();

        // Bypass then stored value
        idle(); rd_wen_i = 1'b1; rd_addr_i = 5'd7; rd_data_i = 32'h1234; rs1_addr_i = 5'd7; step();
        idle(); rs1_addr_i = 5'd7; step();

        // Single load-use hazard and its resolving writeback
        load_issue(5'd3); step();
        idle(); rs2_addr_i = 5'd3; rs2_used_i = 1'b1; step();
        idle(); rs2_addr_i = 5'd3; rs2_used_i = 1'b1; wb_load(5'd3, 32'hAA); step();
        idle(); rs2_addr_i = 5'd3; rs2_used_i = 1'b1; step();

        // Two loads to one register
        load_issue(5'd4); step();
        load_issue(5'd4); step();
        idle(); rs1_addr_i = 5'd4; rs1_used_i = 1'b1; wb_load(5'd4, 32'h11); step();
        idle(); rs1_addr_i = 5'd4; rs1_used_i = 1'b1; wb_load(5'd4, 32'h22); step();
        idle(); rs1_addr_i = 5'd4; rs1_used_i = 1'b1; step();

        // Flushed issue leaves no count behind
        load_issue(5'd9); flush_i = 1'b1; step();
        idle(); rs1_addr_i = 5'd9; rs1_used_i = 1'b1; step();

        // Saturation, underflow and stickiness of the error flag
        for (int i = 0; i < 4; i++) begin
            load_issue(5'd2); step();
        end
        idle(); rs1_addr_i = 5'd2; rs1_used_i = 1'b1; step();
        idle(); wb_load(5'd6, 32'h5); step();
        idle(); step();
        idle(); step();
        idle(); rst = 1'b1; step();
        idle(); rs1_addr_i = 5'd2; rs1_used_i = 1'b1; step();

        // Randomized traffic on a narrow register window to force collisions
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst           = ($urandom_range(0, 149) == 0);
            rd_wen_i      = $urandom_range(0, 1);
            rd_addr_i     = 5'($urandom_range(0, 7));
            rd_data_i     = $urandom;
            mem_re_i      = rd_wen_i && (m_pend[rd_addr_i] > 0 ? ($urandom_range(0, 3) != 0)
                                                               : ($urandom_range(0, 39) == 0));
            rs1_addr_i    = 5'($urandom_range(0, 7));
            rs2_addr_i    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                        : 5'($urandom_range(0, 7));
            rs1_used_i    = $urandom_range(0, 1);
            rs2_used_i    = $urandom_range(0, 1);
            issue_valid_i = $urandom_range(0, 1);
            issue_load_i  = ($urandom_range(0, 2) == 0);
            issue_rd_i    = 5'($urandom_range(0, 7));
            flush_i       = ($urandom_range(0, 9) == 0);
            step();
        end

        idle();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
